// File: rtl/axi_slv_pkg.sv
// Shared response codes, FSM state types and address helpers for the AXI3 slave memory model.
package axi_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    function automatic logic size_legal(input logic [2:0] size, input int data_width);
        return int'(32'd1 << size) <= (data_width / 8);
    endfunction

    // INCR step: align to the transfer size, then advance one transfer.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] step;
        step = 32'd1 << size;
        return (addr & ~(step - 32'd1)) + step;
    endfunction

endpackage

// File: rtl/axi_slv_mem_array.sv
// Byte-lane RAM: one strobed write port and one combinational read port, both addressed per lane
// with wrap-around; a consumer registering the read at the same edge as a write sees the old data.
module axi_slv_mem_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    wrEn_i,
    input  logic [ADD_WIDTH-1:0]    wrAddr_i,
    input  logic [DATA_WIDTH/8-1:0] wrStrb_i,
    input  logic [DATA_WIDTH-1:0]   wrData_i,
    input  logic [ADD_WIDTH-1:0]    rdAddr_i,
    output logic [DATA_WIDTH-1:0]   rdData_o
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADD_WIDTH;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wrStrb_i[i]) begin
                    mem_q[wrAddr_i + ADD_WIDTH'(i)] <= wrData_i[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdData_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rdData_o[i*8 +: 8] = mem_q[rdAddr_i + ADD_WIDTH'(i)];
        end
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory model with independent write (AW/W/B) and read (AR/R) FSMs over a byte RAM.
// Define AXI_SLV_BACKPRESSURE_EN to gate awready/wready/arready with a 16-bit LFSR.
module axi_slave_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    aclk_i,
    input  logic                    areset_i,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADD_WIDTH-1:0]    awaddr_i,
    input  logic [3:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ID_WIDTH-1:0]     wid_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADD_WIDTH-1:0]    araddr_i,
    input  logic [3:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);
    import axi_slv_pkg::*;

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADD_WIDTH-1:0] BUS_MASK = ~ADD_WIDTH'(NUM_LANES - 1);

    wr_state_t             wrState_q;
    logic                  awready_q, wready_q, bvalid_q, wrErr_q;
    logic [ID_WIDTH-1:0]   wrId_q, bid_q;
    logic [ADD_WIDTH-1:0]  wrAddr_q, wrAddr_d;
    logic [3:0]            wrLen_q, wrBeat_q;
    logic [2:0]            wrSize_q;
    logic [1:0]            bresp_q;

    rd_state_t             rdState_q;
    logic                  arready_q, rvalid_q, rlast_q, rdErr_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADD_WIDTH-1:0]  rdAddr_q, rdAddr_d;
    logic [3:0]            rdLen_q, rdBeat_q;
    logic [2:0]            rdSize_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdBeatData;
    logic [1:0]            rresp_q;

    logic                  awHs, wHs, rHs, arHs;
    logic                  wrLastBeat, wBeatErr, memWrEn, arLegal;
    logic [ADD_WIDTH-1:0]  memRdAddr;
    logic [DATA_WIDTH-1:0] memRdData;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        awHold_q, wHold_q, arHold_q;

    // A ready shown without a handshake is kept while the master raises valid, so it is never retracted mid-handshake.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            lfsr_q   <= 16'hACE1;
            awHold_q <= 1'b0;
            wHold_q  <= 1'b0;
            arHold_q <= 1'b0;
        end else begin
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            awHold_q <= awready_o && !awvalid_i;
            wHold_q  <= wready_o && !wvalid_i;
            arHold_q <= arready_o && !arvalid_i;
        end
    end

    assign awready_o = awready_q && (lfsr_q[0] || (awHold_q && awvalid_i));
    assign wready_o  = wready_q && (lfsr_q[5] || (wHold_q && wvalid_i));
    assign arready_o = arready_q && (lfsr_q[10] || (arHold_q && arvalid_i));
`else
    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign arready_o = arready_q;
`endif

    assign awHs = awvalid_i && awready_o;
    assign wHs  = wvalid_i && wready_o;
    assign arHs = arvalid_i && arready_o;
    assign rHs  = rvalid_q && rready_i;

    assign wrLastBeat = (wrBeat_q == wrLen_q);
    assign wBeatErr   = (wlast_i != wrLastBeat) || (wid_i != wrId_q);
    assign memWrEn    = wHs && !wrErr_q && !wBeatErr;
    assign wrAddr_d   = ADD_WIDTH'(next_addr(32'(wrAddr_q), wrSize_q));

    assign arLegal    = size_legal(arsize_i, DATA_WIDTH);
    assign memRdAddr  = ((rdState_q == R_IDLE) ? araddr_i : rdAddr_q) & BUS_MASK;
    assign rdAddr_d   = (rdState_q == R_IDLE) ? ADD_WIDTH'(next_addr(32'(araddr_i), arsize_i))
                                              : ADD_WIDTH'(next_addr(32'(rdAddr_q), rdSize_q));
    assign rdBeatData = ((rdState_q == R_IDLE) ? !arLegal : rdErr_q) ? '0 : memRdData;

    axi_slv_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADD_WIDTH  (ADD_WIDTH)
    ) u_mem (
        .clk_i    (aclk_i),
        .wrEn_i   (memWrEn),
        .wrAddr_i (wrAddr_q & BUS_MASK),
        .wrStrb_i (wstrb_i),
        .wrData_i (wdata_i),
        .rdAddr_i (memRdAddr),
        .rdData_o (memRdData)
    );

    // Write channel: accept one address, absorb exactly awlen+1 beats, then hold the response until taken.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            wrState_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wrId_q    <= '0;
            wrAddr_q  <= '0;
            wrLen_q   <= '0;
            wrSize_q  <= '0;
            wrBeat_q  <= '0;
            wrErr_q   <= 1'b0;
        end else begin
            case (wrState_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awHs) begin
                        wrId_q    <= awid_i;
                        wrAddr_q  <= awaddr_i;
                        wrLen_q   <= awlen_i;
                        wrSize_q  <= awsize_i;
                        wrBeat_q  <= '0;
                        wrErr_q   <= !size_legal(awsize_i, DATA_WIDTH);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wrState_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wHs) begin
                        wrErr_q  <= wrErr_q || wBeatErr;
                        wrAddr_q <= wrAddr_d;
                        wrBeat_q <= wrBeat_q + 4'd1;
                        if (wrLastBeat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= wrId_q;
                            bresp_q   <= (wrErr_q || wBeatErr) ? RESP_SLVERR : RESP_OKAY;
                            wrState_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wrState_q <= W_IDLE;
                    end
                end
                default: wrState_q <= W_IDLE;
            endcase
        end
    end

    // Read channel: each beat is registered when it is presented and held until the master takes it.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            rdState_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rid_q     <= '0;
            rdAddr_q  <= '0;
            rdLen_q   <= '0;
            rdSize_q  <= '0;
            rdBeat_q  <= '0;
            rdErr_q   <= 1'b0;
        end else begin
            case (rdState_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arHs) begin
                        rid_q     <= arid_i;
                        rdLen_q   <= arlen_i;
                        rdSize_q  <= arsize_i;
                        rdErr_q   <= !arLegal;
                        rdAddr_q  <= rdAddr_d;
                        rdBeat_q  <= '0;
                        rdata_q   <= rdBeatData;
                        rresp_q   <= arLegal ? RESP_OKAY : RESP_SLVERR;
                        rlast_q   <= (arlen_i == 4'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rdState_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rHs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rdState_q <= R_IDLE;
                        end else begin
                            rdata_q  <= rdBeatData;
                            rlast_q  <= (rdBeat_q + 4'd1 == rdLen_q);
                            rdBeat_q <= rdBeat_q + 4'd1;
                            rdAddr_q <= rdAddr_d;
                        end
                    end
                end
            endcase
        end
    end

    assign bvalid_o = bvalid_q;
    assign bid_o    = bid_q;
    assign bresp_o  = bresp_q;
    assign rvalid_o = rvalid_q;
    assign rid_o    = rid_q;
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;

endmodule
